// File: rtl/stream_to_bram.sv
// Stream-to-BRAM capture engine: arms on a pulse, waits for its trigger, then writes
// up to L 32-bit stream words into BRAM starting at word 0 and reports done.
module stream_to_bram #(
  parameter int MEM_DEPTH = 2048,
  parameter int AW        = $clog2(MEM_DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        arm,
  input  logic        abort,
  input  logic [1:0]  trig_mode,
  input  logic [15:0] capture_length,
  input  logic        fc_orbitSync,
  input  logic        ext_trigger,
  input  logic [31:0] data_stream_TDATA,
  input  logic        data_stream_TVALID,
  output logic        data_stream_TREADY,
  output logic        bram_CLK,
  output logic        bram_RST,
  output logic        bram_EN,
  output logic [3:0]  bram_WE,
  output logic [31:0] bram_ADDR,
  output logic [31:0] bram_DIN,
  output logic        busy,
  output logic        done,
  output logic [15:0] words_captured
);

  // One extra bit so a full-depth count (e.g. 65536) is representable.
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] len_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] eff_len;
  logic [AW-1:0] addr_q;
  logic [31:0]   din_q;
  logic [31:0]   cnt_ext;
  logic          wr_q;
  logic          trig_gated;
  logic          trig_hit;
  logic          accept;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    eff_len = CW'(MEM_DEPTH);
    if (capture_length != 16'd0 && {16'd0, capture_length} <= 32'(MEM_DEPTH))
      eff_len = CW'(capture_length);
  end

  always_comb begin
    trig_gated = 1'b0;
    trig_hit   = 1'b1;
    case (trig_mode)
      2'd1:    begin trig_gated = 1'b1; trig_hit = fc_orbitSync; end
      2'd2:    begin trig_gated = 1'b1; trig_hit = ext_trigger;  end
      default: begin trig_gated = 1'b0; trig_hit = 1'b1;         end
    endcase
  end

  // A gated trigger captures the beat of its own cycle; arm/abort suppress the beat.
  assign accept  = data_stream_TVALID && !abort && !arm &&
                   (state == S_CAPTURE || (state == S_ARMED && trig_gated && trig_hit));
  assign cnt_inc = cnt_q + CW'(1);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      len_q  <= CW'(MEM_DEPTH);
      cnt_q  <= '0;
      addr_q <= '0;
      din_q  <= '0;
      wr_q   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else if (arm) begin
        state <= S_ARMED;
        len_q <= eff_len;
        cnt_q <= '0;
        busy  <= 1'b1;
        done  <= 1'b0;
      end else begin
        case (state)
          S_ARMED:   if (trig_hit) state <= S_CAPTURE;
          S_CAPTURE: state <= S_CAPTURE;
          S_DONE:    state <= S_DONE;
          default:   state <= S_IDLE;
        endcase
        if (accept) begin
          wr_q   <= 1'b1;
          addr_q <= cnt_q[AW-1:0];
          din_q  <= data_stream_TDATA;
          cnt_q  <= cnt_inc;
          if (cnt_inc == len_q) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
      end
    end
  end

  assign cnt_ext            = 32'(cnt_q);
  assign words_captured     = (cnt_ext > 32'h0000_FFFF) ? 16'hFFFF : cnt_ext[15:0];
  assign data_stream_TREADY = 1'b1;
  assign bram_CLK           = clk;
  assign bram_RST           = reset;
  assign bram_EN            = wr_q;
  assign bram_WE            = {4{wr_q}};
  assign bram_ADDR          = 32'({addr_q, 2'b00});
  assign bram_DIN           = din_q;

endmodule

// File: tb/tb_stream_to_bram.sv
// Bench for stream_to_bram: directed and randomized captures scored against a model that
// picks "the first L valid beats from the capture start" out of the driven beat log.
module tb_stream_to_bram;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm;
  logic        abort;
  logic [1:0]  trig_mode;
  logic [15:0] capture_length;
  logic        fc_orbitSync;
  logic        ext_trigger;
  logic [31:0] data_stream_TDATA;
  logic        data_stream_TVALID;
  logic        data_stream_TREADY;
  logic        bram_CLK;
  logic        bram_RST;
  logic        bram_EN;
  logic [3:0]  bram_WE;
  logic [31:0] bram_ADDR;
  logic [31:0] bram_DIN;
  logic        busy;
  logic        done;
  logic [15:0] words_captured;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]  we;
    logic        en;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t obs[$];

  stream_to_bram #(.MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort), .trig_mode(trig_mode),
    .capture_length(capture_length), .fc_orbitSync(fc_orbitSync), .ext_trigger(ext_trigger),
    .data_stream_TDATA(data_stream_TDATA), .data_stream_TVALID(data_stream_TVALID),
    .data_stream_TREADY(data_stream_TREADY), .bram_CLK(bram_CLK), .bram_RST(bram_RST),
    .bram_EN(bram_EN), .bram_WE(bram_WE), .bram_ADDR(bram_ADDR), .bram_DIN(bram_DIN),
    .busy(busy), .done(done), .words_captured(words_captured)
  );

  always #5 clk = ~clk;

  // Every cycle with any BRAM strobe active is logged as one write.
  always @(negedge clk) begin
    if (bram_WE !== 4'h0 || bram_EN !== 1'b0)
      obs.push_back('{bram_WE, bram_EN, bram_ADDR, bram_DIN});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_writes(input string tag, input logic [31:0] exp_d[$]);
    int n;
    check($sformatf("%s:nwrites", tag), obs.size(), exp_d.size());
    n = (obs.size() < exp_d.size()) ? obs.size() : exp_d.size();
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s:strobe%0d", tag, k), {27'd0, obs[k].we, obs[k].en}, 32'h1F);
      check($sformatf("%s:addr%0d", tag, k), obs[k].addr, 32'(k * 4));
      check($sformatf("%s:data%0d", tag, k), obs[k].data, exp_d[k]);
    end
  endtask

  // vpat: 0 always valid, 1 valid on even steps, 2 random ~70% valid.
  task automatic run_capture(input string tag, input logic [1:0] mode, input logic [15:0] clen,
                             input int trig_at, input int ncyc, input int vpat,
                             input bit counting, input logic [31:0] base);
    logic        vq[$];
    logic [31:0] dq[$];
    logic [31:0] exp_d[$];
    logic        v;
    logic [31:0] d;
    int          len;
    int          start;
    obs.delete();
    trig_mode          = mode;
    capture_length     = clen;
    data_stream_TVALID = 1'b1;
    data_stream_TDATA  = 32'hDEAD_0000;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    capture_length = 16'($urandom);
    for (int i = 0; i < ncyc; i++) begin
      v = (vpat == 0) ? 1'b1 : (vpat == 1) ? (i % 2 == 0) : ($urandom_range(0, 9) < 7);
      d = counting ? base + 32'(i) : $urandom;
      data_stream_TVALID = v;
      data_stream_TDATA  = d;
      fc_orbitSync = (mode == 2'd1) ? (i == trig_at) : 1'($urandom_range(0, 1));
      ext_trigger  = (mode == 2'd2) ? (i == trig_at) : 1'($urandom_range(0, 1));
      vq.push_back(v);
      dq.push_back(d);
      tick();
    end
    data_stream_TVALID = 1'b0;
    fc_orbitSync = 1'b0;
    ext_trigger  = 1'b0;
    tick();
    tick();
    len   = (clen == 16'd0 || int'(clen) > DEPTH) ? DEPTH : int'(clen);
    start = (mode == 2'd1 || mode == 2'd2) ? trig_at : 1;
    for (int i = start; i < ncyc; i++)
      if (vq[i] && exp_d.size() < len) exp_d.push_back(dq[i]);
    check_writes(tag, exp_d);
    check($sformatf("%s:words", tag), 32'(words_captured), exp_d.size());
    check($sformatf("%s:done", tag), 32'(done), 32'(exp_d.size() == len));
    check($sformatf("%s:busy", tag), 32'(busy), 32'(exp_d.size() != len));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_d[$];
    reset = 1'b1; arm = 1'b0; abort = 1'b0; trig_mode = 2'd0; capture_length = 16'd0;
    fc_orbitSync = 1'b0; ext_trigger = 1'b0; data_stream_TDATA = '0; data_stream_TVALID = 1'b0;
    tick();
    tick();
    check("rst:we", 32'(bram_WE), 32'h0);
    check("rst:en", 32'(bram_EN), 32'h0);
    check("rst:addr", bram_ADDR, 32'h0);
    check("rst:din", bram_DIN, 32'h0);
    check("rst:busy", 32'(busy), 32'h0);
    check("rst:done", 32'(done), 32'h0);
    check("rst:words", 32'(words_captured), 32'h0);
    check("rst:tready", 32'(data_stream_TREADY), 32'h1);
    check("rst:bram_rst", 32'(bram_RST), 32'h1);
    reset = 1'b0;
    tick();

    // Directed captures from the test plan.
    run_capture("immediate", 2'd0, 16'd4,   0, 9,  0, 1'b1, 32'h9F);
    run_capture("orbit",     2'd1, 16'd3,  10, 16, 0, 1'b1, 32'h100);
    run_capture("gapped",    2'd0, 16'd5,   0, 14, 1, 1'b1, 32'h200);
    run_capture("clamp0",    2'd0, 16'd0,   0, 20, 0, 1'b0, 32'h0);
    run_capture("clamp100",  2'd0, 16'd100, 0, 20, 0, 1'b0, 32'h0);
    run_capture("len1_ext",  2'd2, 16'd1,   2, 6,  0, 1'b0, 32'h0);
    run_capture("mode3",     2'd3, 16'd6,   0, 12, 2, 1'b0, 32'h0);

    // Abort after two words: the beat in the abort cycle must not land.
    obs.delete();
    trig_mode = 2'd0; capture_length = 16'd8;
    data_stream_TVALID = 1'b1; data_stream_TDATA = 32'h5000;
    arm = 1'b1; tick(); arm = 1'b0;
    tick();
    data_stream_TDATA = 32'h5001; tick();
    data_stream_TDATA = 32'h5002; tick();
    data_stream_TDATA = 32'h5003; abort = 1'b1; tick(); abort = 1'b0;
    for (int i = 0; i < 3; i++) begin data_stream_TDATA = 32'h5010 + 32'(i); tick(); end
    data_stream_TVALID = 1'b0;
    tick();
    exp_d = '{32'h5001, 32'h5002};
    check_writes("abort", exp_d);
    check("abort:words", 32'(words_captured), 32'd2);
    check("abort:done", 32'(done), 32'h0);
    check("abort:busy", 32'(busy), 32'h0);
    run_capture("rearm_ext", 2'd2, 16'd4, 3, 10, 0, 1'b0, 32'h0);

    // Reset in the same cycle as a beat: that beat's write is squashed.
    obs.delete();
    trig_mode = 2'd0; capture_length = 16'd8;
    data_stream_TVALID = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    tick();
    data_stream_TVALID = 1'b1; data_stream_TDATA = 32'h7001; tick();
    data_stream_TDATA = 32'h7002; reset = 1'b1; tick();
    check("rstmid:we", 32'(bram_WE), 32'h0);
    check("rstmid:en", 32'(bram_EN), 32'h0);
    check("rstmid:busy", 32'(busy), 32'h0);
    check("rstmid:done", 32'(done), 32'h0);
    check("rstmid:words", 32'(words_captured), 32'h0);
    check("rstmid:tready", 32'(data_stream_TREADY), 32'h1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    data_stream_TVALID = 1'b0;
    tick();
    exp_d = '{32'h7001};
    check_writes("rstmid", exp_d);
    check("rstmid:tready_after", 32'(data_stream_TREADY), 32'h1);

    // Randomized captures over all modes and lengths around the depth boundary.
    for (int r = 0; r < 8; r++)
      run_capture($sformatf("rand%0d", r), 2'($urandom_range(0, 3)),
                  16'($urandom_range(0, 20)), $urandom_range(0, 5), 40, 2, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
